// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N-input selector.
package mux_pkg;

   localparam int ERR_CNT_W = 8;

   // Select width for n inputs, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < n) r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N_IN x WIDTH selector; codes with no input map to DEFAULT_VAL.
module mux_n_comb
   import mux_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               N_IN        = 7,
   parameter int               SEL_W       = clog2_min1(N_IN),
   parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
   input  logic [N_IN*WIDTH-1:0] in_data_i,
   input  logic [SEL_W-1:0]      sel_i,
   output logic [WIDTH-1:0]      data_o
);

   always_comb begin
      data_o = DEFAULT_VAL;
      for (int k = 0; k < N_IN; k++) begin
         if (sel_i == SEL_W'(k)) data_o = in_data_i[k*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-input selector with valid/ready handshake and select-fault tracking.
module mux_n_reg
   import mux_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               N_IN        = 7,
   parameter int               SEL_W       = clog2_min1(N_IN),
   parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_sel,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  err_clr,
   output logic                  sel_err,
   output logic [ERR_CNT_W-1:0]  err_cnt
);

   localparam logic [SEL_W:0] N_IN_W = (SEL_W+1)'(N_IN);

   logic [WIDTH-1:0]     sel_data;
   logic                 accept;
   logic                 sel_bad;
   logic [WIDTH-1:0]     data_q, data_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

   mux_n_comb #(
      .WIDTH       (WIDTH),
      .N_IN        (N_IN),
      .SEL_W       (SEL_W),
      .DEFAULT_VAL (DEFAULT_VAL)
   ) u_comb (
      .in_data_i (in_data),
      .sel_i     (sel),
      .data_o    (sel_data)
   );

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign sel_bad  = {1'b0, sel} >= N_IN_W;

   always_comb begin
      data_d  = data_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (accept) begin
         data_d  = sel_data;
         sel_d   = sel;
         valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      // A fault accepted on the clearing edge still counts, so the set wins.
      if (accept && sel_bad) begin
         err_d = 1'b1;
         cnt_d = err_clr ? ERR_CNT_W'(1) : sat_inc(cnt_q);
      end else if (err_clr) begin
         err_d = 1'b0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         data_q  <= data_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_data  = data_q;
   assign out_sel   = sel_q;
   assign out_valid = valid_q;
   assign sel_err   = err_q;
   assign err_cnt   = cnt_q;

endmodule
